bcd_serial_add_ctrl: RTL and testbench

Sequencer that adds two multi-digit packed-BCD operands by time-sharing one single-digit BCD adder, least-significant digit first, one digit per clock. It sits between a requesting unit (start/done handshake) and the digit-adder datapath. It holds the operand shift registers, the inter-digit carry, the digit counter and the result register, and flags any non-BCD input digit.

---
 rtl/bcd_pkg.sv | 12 +
 rtl/bcd_digit_add.sv | 23 ++
 rtl/bcd_serial_add_ctrl.sv | 121 ++++++++++++
 tb/tb_bcd_serial_add_ctrl.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared definitions for the serial packed-BCD adder: FSM states and digit constants.
package bcd_pkg;
  localparam int DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] BCD_MAX  = 4'd9;
  localparam logic [DIGIT_W-1:0] BCD_CORR = 4'd6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/bcd_digit_add.sv
// Combinational single-digit BCD adder with decimal correction and non-BCD input flag.
module bcd_digit_add
  import bcd_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout,
  output logic       inv
);

  logic [4:0] z;

  always_comb begin
    z    = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
    cout = (z > {1'b0, BCD_MAX});
    // Correction wraps modulo 16, which also keeps non-BCD inputs deterministic.
    s    = cout ? (z[3:0] + BCD_CORR) : z[3:0];
    inv  = (a > BCD_MAX) | (b > BCD_MAX);
  end

endmodule

// File: rtl/bcd_serial_add_ctrl.sv
// Sequencer adding two packed-BCD operands one digit per clock, LSD first,
// through a single shared bcd_digit_add.
module bcd_serial_add_ctrl
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [4*DIGITS-1:0]     a,
  input  logic [4*DIGITS-1:0]     b,
  output logic                    ready,
  output logic                    busy,
  output logic                    done,
  output logic [4*DIGITS-1:0]     sum,
  output logic                    cout,
  output logic                    err
);

  localparam int W     = DIGIT_W * DIGITS;
  localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DIGITS - 1);

  state_t           state_q, state_d;
  logic [W-1:0]     a_sh_q, a_sh_d;
  logic [W-1:0]     b_sh_q, b_sh_d;
  logic [W-1:0]     sum_q, sum_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             err_q, err_d;

  logic [3:0]       dig_s;
  logic             dig_c;
  logic             dig_inv;

  bcd_digit_add u_digit (
    .a    (a_sh_q[DIGIT_W-1:0]),
    .b    (b_sh_q[DIGIT_W-1:0]),
    .cin  (carry_q),
    .s    (dig_s),
    .cout (dig_c),
    .inv  (dig_inv)
  );

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          carry_d = 1'b0;
          cnt_d   = '0;
          err_d   = 1'b0;
          state_d = ADD;
        end
      end
      ADD: begin
        // The current digit always sits in the low nibble of each shift register.
        a_sh_d  = a_sh_q >> DIGIT_W;
        b_sh_d  = b_sh_q >> DIGIT_W;
        carry_d = dig_c;
        err_d   = err_q | dig_inv;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_IDX) begin
          cout_d  = dig_c;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Each result nibble loads only while its own digit index is being processed.
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_sum
      assign sum_d[gi*DIGIT_W +: DIGIT_W] =
        ((state_q == ADD) && (cnt_q == CNT_W'(gi))) ? dig_s
                                                    : sum_q[gi*DIGIT_W +: DIGIT_W];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      err_q   <= err_d;
    end
  end

  assign ready = (state_q == IDLE);
  assign busy  = (state_q == ADD) || (state_q == DONE);
  assign done  = (state_q == DONE);
  assign sum   = sum_q;
  assign cout  = cout_q;
  assign err   = err_q;

endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// Randomised self-checking bench for bcd_serial_add_ctrl (4-digit and 1-digit instances).
module tb_bcd_serial_add_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        start;
  logic [15:0] a, b;
  logic        ready, busy, done, cout, err;
  logic [15:0] sum;

  logic        start1;
  logic [3:0]  a1, b1;
  logic        ready1, busy1, done1, cout1, err1;
  logic [3:0]  sum1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bcd_serial_add_ctrl #(.DIGITS(4)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .ready(ready), .busy(busy), .done(done), .sum(sum), .cout(cout), .err(err)
  );

  bcd_serial_add_ctrl #(.DIGITS(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1),
    .ready(ready1), .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .err(err1)
  );

  // Reference: digit-by-digit decimal addition with the +6 correction rule, plain integers.
  task automatic model(input logic [15:0] ta, input logic [15:0] tb, input int nd,
                       output logic [15:0] s, output logic co, output logic e);
    int c, da, db, z, d;
    c = 0; s = '0; e = 1'b0;
    for (int i = 0; i < nd; i++) begin
      da = (ta >> (4*i)) & 15;
      db = (tb >> (4*i)) & 15;
      if (da > 9 || db > 9) e = 1'b1;
      z = da + db + c;
      if (z > 9) begin d = (z + 6) % 16; c = 1; end
      else       begin d = z;            c = 0; end
      s = s | (16'(d) << (4*i));
    end
    co = (c != 0);
  endtask

  task automatic run_op(input logic [15:0] ta, input logic [15:0] tb, input bit noise);
    logic [15:0] es; logic ec, ee; int edges;
    model(ta, tb, 4, es, ec, ee);
    @(negedge clk);
    total++;
    if (ready !== 1'b1) begin bad++; $display("FAIL op_ready got=%b want=1", ready); end
    a = ta; b = tb; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = 16'($urandom); b = 16'($urandom);
    edges = 1;
    while (edges < 20) begin
      @(negedge clk);
      edges++;
      if (done === 1'b1) break;
      total++;
      if (busy !== 1'b1 || ready !== 1'b0) begin
        bad++; $display("FAIL op_busy got busy=%b ready=%b want busy=1 ready=0", busy, ready);
      end
      start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    start = 1'b0;
    total++;
    if (done !== 1'b1 || edges != 5) begin
      bad++; $display("FAIL op_latency got done=%b edges=%0d want done=1 edges=5", done, edges);
    end
    total++;
    if (sum !== es || cout !== ec || err !== ee) begin
      bad++;
      $display("FAIL op_result %h+%h got sum=%h cout=%b err=%b want sum=%h cout=%b err=%b",
               ta, tb, sum, cout, err, es, ec, ee);
    end
    $display("op %h+%h -> sum=%h cout=%b err=%b edges=%0d", ta, tb, sum, cout, err, edges);
    @(negedge clk);
    total++;
    if (done !== 1'b0 || ready !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL op_return got done=%b ready=%b busy=%b want 0 1 0", done, ready, busy);
    end
    total++;
    if (sum !== es || cout !== ec || err !== ee) begin
      bad++; $display("FAIL op_hold got sum=%h cout=%b err=%b want sum=%h cout=%b err=%b",
                      sum, cout, err, es, ec, ee);
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    total++;
    if (ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || sum !== 16'h0 ||
        cout !== 1'b0 || err !== 1'b0) begin
      bad++;
      $display("FAIL reset got ready=%b busy=%b done=%b sum=%h cout=%b err=%b want 1 0 0 0000 0 0",
               ready, busy, done, sum, cout, err);
    end
    $display("reset ready=%b busy=%b sum=%h", ready, busy, sum);
    rst = 1'b0;
  endtask

  task automatic test_vectors;
    run_op(16'h1234, 16'h5678, 1'b0);
    run_op(16'h9999, 16'h0001, 1'b0);
    run_op(16'h0999, 16'h0001, 1'b0);
    run_op(16'h9999, 16'h9999, 1'b1);
  endtask

  task automatic test_err_clear;
    run_op(16'h00A0, 16'h0000, 1'b0);
    run_op(16'h0012, 16'h0034, 1'b0);
    run_op(16'hFFFF, 16'hF0F0, 1'b1);
  endtask

  task automatic test_random;
    logic [15:0] ra, rb;
    for (int n = 0; n < 24; n++) begin
      ra = '0; rb = '0;
      for (int i = 0; i < 4; i++) begin
        ra[4*i +: 4] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
        rb[4*i +: 4] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
      end
      run_op(ra, rb, 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_back_to_back;
    int ndone, last, c;
    @(negedge clk);
    a = 16'h0005; b = 16'h0005; start = 1'b1;
    ndone = 0; last = -1;
    for (c = 1; c <= 37; c++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        ndone++;
        total++;
        if (sum !== 16'h0010 || cout !== 1'b0 || err !== 1'b0) begin
          bad++; $display("FAIL b2b_result got sum=%h cout=%b err=%b want 0010 0 0", sum, cout, err);
        end
        if (last >= 0) begin
          total++;
          if (c - last != 6) begin
            bad++; $display("FAIL b2b_period got=%0d want=6", c - last);
          end
        end
        $display("b2b done at cycle %0d sum=%h", c, sum);
        last = c;
      end
    end
    start = 1'b0;
    total++;
    if (ndone != 6) begin bad++; $display("FAIL b2b_count got=%0d want=6", ndone); end
    repeat (8) @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int ndone;
    run_op(16'h4321, 16'h1111, 1'b0);
    @(negedge clk);
    a = 16'h5555; b = 16'h5555; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    total++;
    if (ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || sum !== 16'h0 ||
        cout !== 1'b0 || err !== 1'b0) begin
      bad++;
      $display("FAIL midreset got ready=%b busy=%b done=%b sum=%h cout=%b err=%b want 1 0 0 0000 0 0",
               ready, busy, done, sum, cout, err);
    end
    $display("midreset sum=%h ready=%b", sum, ready);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    repeat (6) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
    end
    total++;
    if (ndone != 0) begin bad++; $display("FAIL midreset_nodone got=%0d want=0", ndone); end
    run_op(16'h0001, 16'h0002, 1'b0);
  endtask

  task automatic one_digit(input logic [3:0] ta, input logic [3:0] tb);
    logic [15:0] es; logic ec, ee; int edges;
    model({12'h0, ta}, {12'h0, tb}, 1, es, ec, ee);
    @(negedge clk);
    a1 = ta; b1 = tb; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0; a1 = 4'($urandom); b1 = 4'($urandom);
    edges = 1;
    while (edges < 10) begin
      @(negedge clk);
      edges++;
      if (done1 === 1'b1) break;
    end
    total++;
    if (done1 !== 1'b1 || edges != 2 || sum1 !== es[3:0] || cout1 !== ec || err1 !== ee) begin
      bad++;
      $display("FAIL one_digit %h+%h got done=%b edges=%0d sum=%h cout=%b err=%b want 1 2 %h %b %b",
               ta, tb, done1, edges, sum1, cout1, err1, es[3:0], ec, ee);
    end
    $display("one_digit %h+%h -> sum=%h cout=%b err=%b edges=%0d", ta, tb, sum1, cout1, err1, edges);
    @(negedge clk);
  endtask

  task automatic test_one_digit;
    one_digit(4'h9, 4'h9);
    one_digit(4'h3, 4'h4);
    one_digit(4'hC, 4'h1);
    for (int n = 0; n < 6; n++) one_digit(4'($urandom), 4'($urandom));
  endtask

  initial begin
    start = 1'b0; a = '0; b = '0;
    start1 = 1'b0; a1 = '0; b1 = '0;
    repeat (3) @(posedge clk);
    test_reset;
    test_vectors;
    test_err_clear;
    test_random;
    test_back_to_back;
    test_reset_mid;
    test_one_digit;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
